// File: rtl/tm1638_spi_writer.sv
// -----------------------------------------------------------------------------
// tm1638_spi_writer
//
// Byte-buffered, write-only 3-wire SPI transmitter for the TM1638 LED&KEY
// board. One activate handshake latches up to OUT_BYTES bytes, which are then
// shifted out under a single CS assertion. SCK idles high; dio changes on the
// falling edge and the chip samples it on the rising edge.
//
// Optional feature macro: TM1638_SPI_TXN_COUNT_EN adds the txn_count output,
// a wrapping count of completed transactions.
//
// Ports:
//   CLOCK_50   in   system clock, all logic on its rising edge
//   reset      in   synchronous, active-low reset
//   activate   in   start request, level-sampled while idle
//   out_data   in   bytes to send, element 0 first
//   out_count  in   number of bytes to send (0 = ignored, clamped to OUT_BYTES)
//   busy       out  high from the cycle after acceptance until the CS gap ends
//   sck        out  SPI clock (idle high)
//   dio        out  serial data (idle high)
//   cs         out  chip select, active low
//   state_dbg  out  current FSM state encoding, for observation only
//   txn_count  out  completed transaction count (only with the macro above)
//
// Handshake: activate acts as "valid" and !busy as "ready". A request is
// accepted on a rising edge where the FSM is idle, activate=1 and
// out_count!=0; busy rises the next cycle and the input bus is don't-care
// from then on. activate is ignored while busy=1; if it is still high when
// busy falls, another transaction is accepted on the next idle cycle.
// -----------------------------------------------------------------------------
module tm1638_spi_writer #(
   parameter int CLK_DIV        = 20,
   parameter int OUT_BYTES      = 5,
   parameter int OUT_BYTES_SZ   = $clog2(OUT_BYTES + 1),
   parameter int ALL_DONE_DELAY = 1,
   parameter int LSB_FIRST      = 1
) (
   input  logic                      CLOCK_50,
   input  logic                      reset,
   input  logic                      activate,
   input  logic [OUT_BYTES-1:0][7:0] out_data,
   input  logic [OUT_BYTES_SZ-1:0]   out_count,
   output logic                      busy,
   output logic                      sck,
   output logic                      dio,
   output logic                      cs,
   output logic [2:0]                state_dbg
`ifdef TM1638_SPI_TXN_COUNT_EN
   ,
   output logic [15:0]               txn_count
`endif
);

   localparam int HALF     = CLK_DIV / 2;
   localparam int HOLD_CYC = ALL_DONE_DELAY * HALF;
   localparam int TMR_MAX  = (HOLD_CYC > CLK_DIV) ? HOLD_CYC : CLK_DIV;
   localparam int TMR_W    = $clog2(TMR_MAX + 1);

   // Timer is loaded with (duration - 1) and the state ends when it reads 0.
   localparam logic [TMR_W-1:0]        HALF_LD = TMR_W'(HALF - 1);
   localparam logic [TMR_W-1:0]        GAP_LD  = TMR_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0]        HOLD_LD = TMR_W'(HOLD_CYC - 1);
   localparam logic [TMR_W-1:0]        TMR_ONE = TMR_W'(1);
   localparam logic [OUT_BYTES_SZ-1:0] MAX_CNT = OUT_BYTES_SZ'(OUT_BYTES);
   localparam logic [OUT_BYTES_SZ-1:0] CNT_ONE = OUT_BYTES_SZ'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CS_SETUP = 3'd1,
      S_SHIFT_LO = 3'd2,
      S_SHIFT_HI = 3'd3,
      S_HOLD     = 3'd4,
      S_GAP      = 3'd5
   } state_t;

   state_t                      state_q, state_d;
   logic [TMR_W-1:0]            tmr_q, tmr_d;
   logic [2:0]                  bit_q, bit_d;
   logic [OUT_BYTES_SZ-1:0]     byte_q, byte_d;
   logic [OUT_BYTES_SZ-1:0]     cnt_q, cnt_d;
   logic [OUT_BYTES-1:0][7:0]   buf_q, buf_d;
   logic                        busy_q, busy_d;
   logic                        sck_q, sck_d;
   logic                        cs_q, cs_d;
   logic                        dio_q, dio_d;
   logic                        last_bit;

   // Bit k of the serial stream within one byte, honouring the bit order.
   function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] k);
      return (LSB_FIRST != 0) ? b[k] : b[3'd7 - k];
   endfunction

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         busy_q  <= 1'b0;
         sck_q   <= 1'b1;
         cs_q    <= 1'b1;
         dio_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         busy_q  <= busy_d;
         sck_q   <= sck_d;
         cs_q    <= cs_d;
         dio_q   <= dio_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      cnt_d    = cnt_q;
      buf_d    = buf_q;
      busy_d   = busy_q;
      sck_d    = sck_q;
      cs_d     = cs_q;
      dio_d    = dio_q;
      last_bit = (bit_q == 3'd7) && (byte_q == cnt_q - CNT_ONE);

      unique case (state_q)
         S_IDLE: begin
            if (activate && (out_count != '0)) begin
               state_d = S_CS_SETUP;
               tmr_d   = HALF_LD;
               busy_d  = 1'b1;
               cs_d    = 1'b0;
               sck_d   = 1'b1;
               bit_d   = '0;
               byte_d  = '0;
               buf_d   = out_data;
               cnt_d   = (out_count > MAX_CNT) ? MAX_CNT : out_count;
               // First bit is already on dio during CS setup.
               dio_d   = pick_bit(out_data[0], 3'd0);
            end
         end

         S_CS_SETUP: begin
            if (tmr_q == '0) begin
               state_d = S_SHIFT_LO;
               tmr_d   = HALF_LD;
               sck_d   = 1'b0;
               dio_d   = pick_bit(buf_q[byte_q], bit_q);
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end

         S_SHIFT_LO: begin
            if (tmr_q == '0) begin
               state_d = S_SHIFT_HI;
               tmr_d   = HALF_LD;
               sck_d   = 1'b1;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end

         S_SHIFT_HI: begin
            if (tmr_q == '0) begin
               if (last_bit) begin
                  dio_d = 1'b1;
                  if (HOLD_CYC == 0) begin
                     // No hold requested: go straight to the CS-high gap.
                     state_d = S_GAP;
                     tmr_d   = GAP_LD;
                     cs_d    = 1'b1;
                  end else begin
                     state_d = S_HOLD;
                     tmr_d   = HOLD_LD;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     byte_d = byte_q + CNT_ONE;
                  end
                  state_d = S_SHIFT_LO;
                  tmr_d   = HALF_LD;
                  sck_d   = 1'b0;
                  dio_d   = pick_bit(buf_q[byte_d], bit_d);
               end
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end

         S_HOLD: begin
            if (tmr_q == '0) begin
               state_d = S_GAP;
               tmr_d   = GAP_LD;
               cs_d    = 1'b1;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end

         S_GAP: begin
            if (tmr_q == '0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef TM1638_SPI_TXN_COUNT_EN
   // Counts only transactions that reach the end of the gap, i.e. the same
   // edge on which busy falls. Aborts and ignored requests never get there.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         txn_count <= '0;
      end else if ((state_q == S_GAP) && (tmr_q == '0)) begin
         txn_count <= txn_count + 16'd1;
      end
   end
`endif

   assign busy      = busy_q;
   assign sck       = sck_q;
   assign cs        = cs_q;
   assign dio       = dio_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_tm1638_spi_writer.sv
// -----------------------------------------------------------------------------
// tb_tm1638_spi_writer
//
// Directed-plus-random bench for tm1638_spi_writer. Two instances share the
// clock and reset: dut (LSB first, defaults) and dut_m (MSB first). A sampling
// task observes both on the falling clock edge, collecting the dio value at
// every sck rising edge plus cycle counts for busy and cs. Expected bytes and
// busy lengths come from the bench's own model of the serial framing.
// -----------------------------------------------------------------------------
module tb_tm1638_spi_writer;

   localparam int CLK_DIV        = 20;
   localparam int OUT_BYTES      = 5;
   localparam int OUT_BYTES_SZ   = $clog2(OUT_BYTES + 1);
   localparam int ALL_DONE_DELAY = 1;
   localparam int HALF           = CLK_DIV / 2;

   typedef logic [OUT_BYTES-1:0][7:0] buf_t;

   // ---------------- clock / reset ----------------
   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   // ---------------- DUT signals ----------------
   logic                    activate  = 1'b0;
   buf_t                    out_data  = '0;
   logic [OUT_BYTES_SZ-1:0] out_count = '0;
   logic                    busy, sck, dio, cs;
   logic [2:0]              state_dbg;

   logic                    activate_m  = 1'b0;
   buf_t                    out_data_m  = '0;
   logic [OUT_BYTES_SZ-1:0] out_count_m = '0;
   logic                    busy_m, sck_m, dio_m, cs_m;
   logic [2:0]              state_dbg_m;
`ifdef TM1638_SPI_TXN_COUNT_EN
   logic [15:0]             txn_count, txn_count_m;
`endif

   tm1638_spi_writer #(
      .CLK_DIV(CLK_DIV), .OUT_BYTES(OUT_BYTES), .OUT_BYTES_SZ(OUT_BYTES_SZ),
      .ALL_DONE_DELAY(ALL_DONE_DELAY), .LSB_FIRST(1)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .activate(activate),
      .out_data(out_data), .out_count(out_count), .busy(busy), .sck(sck),
      .dio(dio), .cs(cs), .state_dbg(state_dbg)
`ifdef TM1638_SPI_TXN_COUNT_EN
      , .txn_count(txn_count)
`endif
   );

   tm1638_spi_writer #(
      .CLK_DIV(CLK_DIV), .OUT_BYTES(OUT_BYTES), .OUT_BYTES_SZ(OUT_BYTES_SZ),
      .ALL_DONE_DELAY(ALL_DONE_DELAY), .LSB_FIRST(0)
   ) dut_m (
      .CLOCK_50(CLOCK_50), .reset(reset), .activate(activate_m),
      .out_data(out_data_m), .out_count(out_count_m), .busy(busy_m), .sck(sck_m),
      .dio(dio_m), .cs(cs_m), .state_dbg(state_dbg_m)
`ifdef TM1638_SPI_TXN_COUNT_EN
      , .txn_count(txn_count_m)
`endif
   );

   // ---------------- scoreboard state ----------------
   int         n_cmp = 0;
   int         n_mis = 0;
   logic [7:0] exp_q[$];
   int         exp_len;
   int         n_done = 0;
   logic [2:0] idle_state;

   // observation accumulators
   int   cyc = 0;
   int   n_rise, n_fall, n_cs_fall, n_busy_rise, cs_low, busy_hi, idle_bad;
   int   first_busy, first_fall;
   int   busy_rise_cyc[$];
   int   cs_rise_cyc[$];
   int   cs_fall_cyc[$];
   logic bits_q[$];
   logic bits_m_q[$];
   logic p_sck = 1'b1, p_cs = 1'b1, p_busy = 1'b0, p_sck_m = 1'b1;

   initial begin
      #(20 * 80000);
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int busy_len(input int n);
      return HALF + 8 * n * CLK_DIV + ALL_DONE_DELAY * HALF + CLK_DIV;
   endfunction

   function automatic buf_t rand_bytes();
      buf_t r;
      for (int i = 0; i < OUT_BYTES; i++) r[i] = 8'($urandom_range(0, 255));
      return r;
   endfunction

   task automatic mon_clear();
      n_rise = 0; n_fall = 0; n_cs_fall = 0; n_busy_rise = 0;
      cs_low = 0; busy_hi = 0; idle_bad = 0;
      first_busy = -1; first_fall = -1;
      busy_rise_cyc.delete(); cs_rise_cyc.delete(); cs_fall_cyc.delete();
      bits_q.delete(); bits_m_q.delete();
   endtask

   // Advance n cycles, sampling both instances on the falling clock edge.
   task automatic step(input int n);
      repeat (n) begin
         @(negedge CLOCK_50);
         cyc++;
         if (sck && !p_sck) begin
            bits_q.push_back(dio);
            n_rise++;
         end
         if (!sck && p_sck) begin
            n_fall++;
            if (first_fall < 0) first_fall = cyc;
         end
         if (!cs && p_cs) begin
            n_cs_fall++;
            cs_fall_cyc.push_back(cyc);
         end
         if (cs && !p_cs) cs_rise_cyc.push_back(cyc);
         if (!cs) cs_low++;
         if (busy) busy_hi++;
         if (busy && !p_busy) begin
            n_busy_rise++;
            busy_rise_cyc.push_back(cyc);
            if (first_busy < 0) first_busy = cyc;
         end
         if (!(sck === 1'b1 && cs === 1'b1 && dio === 1'b1 && busy === 1'b0)) idle_bad++;
         if (sck_m && !p_sck_m) bits_m_q.push_back(dio_m);
         p_sck = sck; p_cs = cs; p_busy = busy; p_sck_m = sck_m;
      end
   endtask

   // Model: the transaction carries min(n, OUT_BYTES) bytes in element order.
   task automatic send(input int n, input buf_t d);
      int ne;
      ne = (n > OUT_BYTES) ? OUT_BYTES : n;
      exp_q.delete();
      for (int i = 0; i < ne; i++) exp_q.push_back(d[i]);
      exp_len = busy_len(ne);
      mon_clear();
      out_count = OUT_BYTES_SZ'(n);
      out_data  = d;
      activate  = 1'b1;
      step(1);
      activate  = 1'b0;
      out_data  = rand_bytes();
      out_count = OUT_BYTES_SZ'($urandom_range(0, 7));
   endtask

   task automatic wait_done(input int bound, input string tag);
      int k;
      k = 0;
      while ((n_busy_rise == 0 || busy !== 1'b0) && k < bound) begin
         step(1);
         k++;
      end
      check({tag, "_in_time"}, int'(k < bound), 1);
   endtask

   // Rebuild each byte from the captured bit stream (LSB first) and compare.
   task automatic score(input string tag);
      logic [7:0] got;
      check({tag, "_nbits"}, bits_q.size(), 8 * exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         got = '0;
         for (int j = 0; j < 8; j++)
            if (8 * i + j < bits_q.size()) got[j] = bits_q[8 * i + j];
         check($sformatf("%s_byte%0d", tag, i), int'(got), int'(exp_q[i]));
      end
   endtask

   task automatic finish_txn(input string tag);
      wait_done(2000, tag);
      score(tag);
      check({tag, "_busy_len"}, busy_hi, exp_len);
      check({tag, "_cs_low"}, cs_low, exp_len - CLK_DIV);
      check({tag, "_cs_windows"}, n_cs_fall, 1);
      check({tag, "_back_idle"}, int'(state_dbg), int'(idle_state));
      n_done++;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      buf_t       d;
      int         k;
      int         gap;
      logic [7:0] seq;

      // Reset held for 3 cycles, then 1000 quiet cycles.
      mon_clear();
      reset = 1'b0;
      step(3);
      check("rst_sck", int'(sck), 1);
      check("rst_cs", int'(cs), 1);
      check("rst_dio", int'(dio), 1);
      check("rst_busy", int'(busy), 0);
      idle_state = state_dbg;
      reset = 1'b1;
      mon_clear();
      step(1000);
      check("quiet_idle_bad", idle_bad, 0);
      check("quiet_sck_falls", n_fall, 0);
      check("quiet_busy_rises", n_busy_rise, 0);
`ifdef TM1638_SPI_TXN_COUNT_EN
      check("txn_count_reset", int'(txn_count), 0);
`endif

      // Single byte 0x40: stream 0,0,0,0,0,0,1,0.
      d = '0;
      d[0] = 8'h40;
      send(1, d);
      finish_txn("one_byte");
      check("one_byte_sck_falls", n_fall, 8);
      check("one_byte_first_fall", first_fall - first_busy, HALF);

      // Five bytes C0,01,02,04,08.
      d = {8'h08, 8'h04, 8'h02, 8'h01, 8'hC0};
      send(5, d);
      finish_txn("five_bytes");
      check("five_bytes_rises", n_rise, 40);

      // MSB-first instance with 0x8F: stream 1,0,0,0,1,1,1,1.
      mon_clear();
      out_data_m    = '0;
      out_data_m[0] = 8'h8F;
      out_count_m   = 1;
      activate_m    = 1'b1;
      step(1);
      activate_m    = 1'b0;
      step(250);
      seq = '0;
      for (int j = 0; j < 8; j++)
         if (j < bits_m_q.size()) seq[7 - j] = bits_m_q[j];
      check("msb_nbits", bits_m_q.size(), 8);
      check("msb_order", int'(seq), int'(8'b1000_1111));
      check("msb_idle", int'(busy_m), 0);
      check("msb_back_idle", int'(state_dbg_m), int'(idle_state));
`ifdef TM1638_SPI_TXN_COUNT_EN
      check("msb_txn_count", int'(txn_count_m), 1);
`endif

      // out_count=0 with activate held 50 cycles is ignored.
      mon_clear();
      out_data  = rand_bytes();
      out_count = '0;
      activate  = 1'b1;
      step(50);
      activate  = 1'b0;
      step(5);
      check("zero_busy_rises", n_busy_rise, 0);
      check("zero_cs_falls", n_cs_fall, 0);
      check("zero_sck_falls", n_fall, 0);

      // out_count=7 is clamped to OUT_BYTES.
      send(7, rand_bytes());
      finish_txn("clamp");
      check("clamp_rises", n_rise, 40);

      // Random transactions, each with an ignored activate pulse mid-flight.
      for (int t = 0; t < 4; t++) begin
         send($urandom_range(1, OUT_BYTES), rand_bytes());
         step(100);
         out_data  = rand_bytes();
         out_count = OUT_BYTES_SZ'(OUT_BYTES);
         activate  = 1'b1;
         step(4);
         check($sformatf("rand%0d_busy_state", t), int'(state_dbg !== idle_state), 1);
         activate  = 1'b0;
         finish_txn($sformatf("rand%0d", t));
      end

      // activate held high: two back-to-back transactions.
      mon_clear();
      d = rand_bytes();
      out_data  = d;
      out_count = 1;
      activate  = 1'b1;
      k = 0;
      while (n_busy_rise < 2 && k < 1000) begin
         step(1);
         k++;
      end
      activate = 1'b0;
      check("b2b_accepts", n_busy_rise, 2);
      wait_done(2000, "b2b");
      exp_q.delete();
      exp_q.push_back(d[0]);
      exp_q.push_back(d[0]);
      score("b2b");
      check("b2b_interval",
            (busy_rise_cyc.size() >= 2) ? busy_rise_cyc[1] - busy_rise_cyc[0] : -1,
            busy_len(1) + 1);
      gap = (cs_fall_cyc.size() >= 2 && cs_rise_cyc.size() >= 1) ?
            cs_fall_cyc[1] - cs_rise_cyc[0] : -1;
      check("b2b_cs_gap_min", int'(gap >= CLK_DIV), 1);
      n_done += 2;

      // Abort with reset at bit 12 of a 5-byte transfer.
      send(5, rand_bytes());
      k = 0;
      while (n_rise < 12 && k < 600) begin
         step(1);
         k++;
      end
      check("abort_reach_bit12", n_rise, 12);
      reset = 1'b0;
      step(1);
      check("abort_cs", int'(cs), 1);
      check("abort_sck", int'(sck), 1);
      check("abort_busy", int'(busy), 0);
      reset = 1'b1;
      mon_clear();
      step(200);
      check("abort_no_restart", n_busy_rise, 0);
      check("abort_no_sck", n_fall, 0);
`ifdef TM1638_SPI_TXN_COUNT_EN
      // Reset clears the counter; the abort itself adds nothing.
      check("abort_txn_count", int'(txn_count), 0);
`endif
      send(2, rand_bytes());
      finish_txn("after_abort");
`ifdef TM1638_SPI_TXN_COUNT_EN
      check("after_abort_txn_count", int'(txn_count), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
